// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: opcodes, sequencer states,
// ALU operation classes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // States that hold a memory request open until MemReady.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of an open memory request and flags the
// cycle on which the request has waited MEM_TIMEOUT cycles without MemReady.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // A request always ends on ready, and every mem state is entered from a
    // non-waiting cycle, so clearing on ready/inactive covers every state change.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (!active || ready)
            count <= '0;
        else if (count != LAST)
            count <= count + CW'(1);
    end

    assign timeout = active && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle MIPS datapath: state register, next-state
// logic and per-state control strobes, with a memory wait-state timeout.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic       MemFault
);
    state_t state, next_state;
    logic   timeout;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .active  (is_mem_state(state)),
        .ready   (MemReady),
        .timeout (timeout)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= FETCH;
            MemFault <= 1'b0;
        end else if (timeout) begin
            state    <= HALT;
            MemFault <= 1'b1;
        end else begin
            state    <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:  if (MemReady) next_state = DECODE;
            DECODE: begin
                unique case (Op)
                    OP_RTYPE:     next_state = EXEC;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: next_state = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (MemReady) next_state = MEMWB;
            MEMWR:  if (MemReady) next_state = FETCH;
            EXEC:   next_state = RWB;
            ADDIEX: next_state = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUB_RT;
        ALUOp       = ALUOP_ADD;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        IllegalOp   = 1'b0;
        unique case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB   = ALUB_IMM_SH2;
                IllegalOp = !(Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ADDIWB:  RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule
